usb_pkt_rx: RTL

//  Packet-level USB receiver. Consumes the byte stream from usb_rx (ready/eop/data) and delivers decoded packets.

---
 rtl/usb_pkt_rx_pkg.sv | 71 +++++++
 rtl/usb_pkt_rx_crc16.sv | 33 +++
 rtl/usb_pkt_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/usb_pkt_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkt_rx_pkg
// Brief    : Shared constants for the USB packet receiver: SYNC byte, PID
//            codes, CRC polynomials/presets/residuals, FSM state encodings,
//            error codes and byte-wide CRC helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkt_rx_pkg;

  localparam logic [7:0]  c_SYNC_BYTE     = 8'h80;

  // PID[3:0] codes
  localparam logic [3:0]  c_PID_OUT       = 4'h1;
  localparam logic [3:0]  c_PID_IN        = 4'h9;
  localparam logic [3:0]  c_PID_SOF       = 4'h5;
  localparam logic [3:0]  c_PID_SETUP     = 4'hD;
  localparam logic [3:0]  c_PID_DATA0     = 4'h3;
  localparam logic [3:0]  c_PID_DATA1     = 4'hB;
  localparam logic [3:0]  c_PID_ACK       = 4'h2;
  localparam logic [3:0]  c_PID_NAK       = 4'hA;
  localparam logic [3:0]  c_PID_STALL     = 4'hE;

  // CRC definitions (bit 4 / bit 15 holds the highest-order coefficient)
  localparam logic [4:0]  c_CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  c_CRC5_PRESET   = 5'h1F;
  localparam logic [4:0]  c_CRC5_RESID    = 5'b01100;
  localparam logic [15:0] c_CRC16_POLY    = 16'h8005;
  localparam logic [15:0] c_CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] c_CRC16_RESID   = 16'h800D;

  // err_code values
  localparam logic [2:0]  c_ERR_NONE      = 3'd0;
  localparam logic [2:0]  c_ERR_PID       = 3'd1;
  localparam logic [2:0]  c_ERR_CRC       = 3'd2;
  localparam logic [2:0]  c_ERR_LEN       = 3'd3;
  localparam logic [2:0]  c_ERR_UNEXP     = 3'd4;
  localparam logic [2:0]  c_ERR_EOP       = 3'd5;

  // FSM state encodings
  localparam logic [2:0]  ST_IDLE         = 3'd0;
  localparam logic [2:0]  ST_PID          = 3'd1;
  localparam logic [2:0]  ST_TOKEN        = 3'd2;
  localparam logic [2:0]  ST_DATA         = 3'd3;
  localparam logic [2:0]  ST_HSHK         = 3'd4;
  localparam logic [2:0]  ST_DRAIN        = 3'd5;

  // Advance CRC5 by one byte, LSB first (wire order)
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ c_CRC5_POLY;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  // Advance CRC16 by one byte, LSB first (wire order)
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ c_CRC16_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_pkt_rx_crc16.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkt_rx_crc16
// Brief    : Byte-wide CRC16 register (poly 0x8005, preset 0xFFFF). Also
//            exposes the value it will hold after the current byte so that
//            an EOP arriving with the last byte can be checked immediately.
// Revision : 1.0 - initial release
// ============================================================================
module usb_pkt_rx_crc16
  import usb_pkt_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc,
  output logic [15:0] o_crc_nxt
);

  logic [15:0] r_crc;

  assign o_crc_nxt = i_en ? crc16_byte(r_crc, i_data) : r_crc;
  assign o_crc     = r_crc;

  // CRC register: preset on reset/clear, otherwise follow the next value
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_crc <= c_CRC16_PRESET;
    else              r_crc <= o_crc_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/usb_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkt_rx
// Brief    : Packet-level USB receiver. Frames SYNC..EOP, validates the PID,
//            checks CRC5 (tokens) / CRC16 (data), streams data payload with
//            the CRC bytes stripped and reports one status per packet.
// Revision : 1.0 - initial release
// ============================================================================
module usb_pkt_rx
  import usb_pkt_rx_pkg::*;
#(
  parameter int MAX_LEN = 64
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_ready,
  input  logic       i_rx_eop,
  input  logic [7:0] i_rx_data,
  output logic       o_pkt_start,
  output logic [3:0] o_pid,
  output logic [6:0] o_tok_addr,
  output logic [3:0] o_tok_endp,
  output logic       o_dat_valid,
  output logic [7:0] o_dat_byte,
  output logic       o_pkt_done,
  output logic       o_pkt_ok,
  output logic [2:0] o_err_code
);

  localparam int             CNT_W     = $clog2(MAX_LEN + 3);
  localparam logic [CNT_W-1:0] c_TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_LEN_LIM = CNT_W'(MAX_LEN + 2);

  logic [2:0]       r_state, w_st_b, w_st_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_b;
  logic             r_over, w_over_b;
  logic [2:0]       r_err, w_err_b, w_err;
  logic [4:0]       r_crc5, w_crc5_b;
  logic [7:0]       r_d0, r_d1, r_tok0, r_tok1, w_tok0, w_tok1;
  logic [15:0]      w_crc16, w_crc16_nxt, w_crc16_chk;
  logic             w_pid_ok, w_byte_tok, w_byte_dat;
  logic             w_pkt_start, w_emit, w_done;

  assign w_pid_ok   = (i_rx_data[7:4] == ~i_rx_data[3:0]);
  assign w_byte_tok = i_rx_ready && (r_state == ST_TOKEN);
  assign w_byte_dat = i_rx_ready && (r_state == ST_DATA);

  // Byte-level datapath values as they stand after this cycle's byte
  assign w_cnt_b     = (i_rx_ready && (r_state == ST_TOKEN || r_state == ST_DATA) && r_cnt != '1)
                       ? r_cnt + 1'b1 : r_cnt;
  assign w_over_b    = r_over || (w_byte_dat && r_cnt >= c_LEN_LIM);
  assign w_crc5_b    = w_byte_tok ? crc5_byte(r_crc5, i_rx_data) : r_crc5;
  assign w_tok0      = (w_byte_tok && r_cnt == '0)         ? i_rx_data : r_tok0;
  assign w_tok1      = (w_byte_tok && r_cnt == CNT_W'(1))  ? i_rx_data : r_tok1;
  assign w_crc16_chk = w_byte_dat ? w_crc16_nxt : w_crc16;

  usb_pkt_rx_crc16 u_crc16 (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_st_n != ST_DATA),
    .i_en      (w_byte_dat),
    .i_data    (i_rx_data),
    .o_crc     (w_crc16),
    .o_crc_nxt (w_crc16_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_st_n;
  end

  // Next state: apply the byte first, then a same-cycle EOP on the result
  always_comb begin
    w_st_b  = r_state;
    w_err_b = r_err;
    if (i_rx_ready) begin
      case (r_state)
        ST_IDLE: if (i_rx_data == c_SYNC_BYTE) w_st_b = ST_PID;
        ST_PID: begin
          if (!w_pid_ok) begin
            w_st_b  = ST_DRAIN;
            w_err_b = c_ERR_PID;
          end else begin
            case (i_rx_data[1:0])
              2'b01:   w_st_b = ST_TOKEN;
              2'b11:   w_st_b = ST_DATA;
              default: w_st_b = ST_HSHK;
            endcase
          end
        end
        ST_HSHK: begin
          w_st_b  = ST_DRAIN;
          w_err_b = c_ERR_UNEXP;
        end
        default: w_st_b = r_state;
      endcase
    end
    w_st_n = w_st_b;
    if (i_rx_eop && w_st_b != ST_IDLE) w_st_n = ST_IDLE;
  end

  // Output decode: strobes and the final error code of the packet
  always_comb begin
    w_pkt_start = i_rx_ready && (r_state == ST_PID) && w_pid_ok;
    w_emit      = w_byte_dat && (r_cnt >= c_TWO) && (r_cnt < c_LEN_LIM);
    w_done      = i_rx_eop && (w_st_b != ST_IDLE);
    w_err       = c_ERR_NONE;
    case (w_st_b)
      ST_PID:   w_err = c_ERR_EOP;
      ST_TOKEN: begin
        // length is reported in preference to a CRC failure
        if (w_cnt_b != c_TWO)               w_err = c_ERR_LEN;
        else if (w_crc5_b != c_CRC5_RESID)  w_err = c_ERR_CRC;
      end
      ST_DATA: begin
        if (w_cnt_b < c_TWO || w_over_b)    w_err = c_ERR_LEN;
        else if (w_crc16_chk != c_CRC16_RESID) w_err = c_ERR_CRC;
      end
      ST_DRAIN: w_err = w_err_b;
      default:  w_err = c_ERR_NONE;
    endcase
  end

  // Per-packet datapath: counters, CRC5, delay line, token bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_over <= 1'b0;
      r_err  <= c_ERR_NONE;
      r_crc5 <= c_CRC5_PRESET;
      r_d0   <= '0;
      r_d1   <= '0;
      r_tok0 <= '0;
      r_tok1 <= '0;
    end else begin
      r_cnt  <= (w_st_n == ST_TOKEN || w_st_n == ST_DATA) ? w_cnt_b : '0;
      r_over <= (w_st_n == ST_DATA) ? w_over_b : 1'b0;
      r_err  <= (w_st_n == ST_DRAIN) ? w_err_b : c_ERR_NONE;
      r_crc5 <= (w_st_n == ST_TOKEN) ? w_crc5_b : c_CRC5_PRESET;
      r_tok0 <= w_tok0;
      r_tok1 <= w_tok1;
      if (w_byte_dat) begin
        r_d1 <= r_d0;
        r_d0 <= i_rx_data;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pkt_start <= 1'b0;
      o_pid       <= '0;
      o_tok_addr  <= '0;
      o_tok_endp  <= '0;
      o_dat_valid <= 1'b0;
      o_dat_byte  <= '0;
      o_pkt_done  <= 1'b0;
      o_pkt_ok    <= 1'b0;
      o_err_code  <= c_ERR_NONE;
    end else begin
      o_pkt_start <= w_pkt_start;
      o_dat_valid <= w_emit;
      o_pkt_done  <= w_done;
      o_pkt_ok    <= w_done && (w_err == c_ERR_NONE);
      if (w_pkt_start) o_pid <= i_rx_data[3:0];
      if (w_emit)      o_dat_byte <= r_d1;
      if (w_done) begin
        o_err_code <= w_err;
        if (w_st_b == ST_TOKEN) begin
          o_tok_addr <= w_tok0[6:0];
          o_tok_endp <= {w_tok1[2:0], w_tok0[7]};
        end
      end
    end
  end

endmodule
`default_nettype wire
